spi_flash_reader: RTL and testbench

SPI_FLASH_READER -- requirements
Module: spi_flash_reader

---
 rtl/spi_flash_reader.sv | 164 ++++++++++++++++
 tb/tb_spi_flash_reader.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_flash_reader.sv
// Serial-flash read sequencer driving a byte-level SPI core; streams read bytes out on valid/ready.
// Build option: define SPI_FLASH_FAST_READ_EN for FAST READ (0x0B + dummy byte), else READ (0x03).
module spi_flash_reader #(
  parameter int LEN_WIDTH      = 8,
  parameter int START_HOLD_MAX = 63
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req,
  input  logic [23:0]          addr,
  input  logic [LEN_WIDTH-1:0] len,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [7:0]           rd_data,
  output logic                 rd_valid,
  input  logic                 rd_ready,
  output logic                 spi_start,
  output logic [7:0]           spi_tx,
  input  logic [7:0]           spi_rx,
  input  logic                 spi_busy,
  output logic                 flash_cs_n
);

`ifdef SPI_FLASH_FAST_READ_EN
  localparam logic [7:0] OPCODE = 8'h0B;
`else
  localparam logic [7:0] OPCODE = 8'h03;
`endif
  localparam int HW = $clog2(START_HOLD_MAX + 1);
  localparam logic [HW-1:0]        HOLD_LAST = HW'(START_HOLD_MAX - 1);
  localparam logic [LEN_WIDTH:0]   CNT_ONE   = {{LEN_WIDTH{1'b0}}, 1'b1};

  typedef enum logic [3:0] {IDLE, CMD, A2, A1, A0, DUMMY, DATA, OUT, FIN} state_t;
  typedef enum logic [1:0] {ISSUE, WAIT_HI, WAIT_LO} phase_t;

  state_t             state_q;
  state_t             after_xfer_d;
  phase_t             phase_q;
  logic [HW-1:0]      hold_q;
  logic [LEN_WIDTH:0] cnt_q;
  logic [23:0]        addr_q;
  logic [7:0]         tx_d;
  logic               busy_q, done_q, err_q, rd_valid_q, spi_start_q, cs_n_q;
  logic [7:0]         rd_data_q, spi_tx_q;

  // Byte to send in the current exchange state and the state that follows it.
  always_comb begin
    tx_d         = 8'h00;
    after_xfer_d = FIN;
    case (state_q)
      CMD:   begin tx_d = OPCODE;        after_xfer_d = A2;    end
      A2:    begin tx_d = addr_q[23:16]; after_xfer_d = A1;    end
      A1:    begin tx_d = addr_q[15:8];  after_xfer_d = A0;    end
`ifdef SPI_FLASH_FAST_READ_EN
      A0:    begin tx_d = addr_q[7:0];   after_xfer_d = DUMMY; end
`else
      A0:    begin tx_d = addr_q[7:0];   after_xfer_d = DATA;  end
`endif
      DUMMY: begin tx_d = 8'h00;         after_xfer_d = DATA;  end
      DATA:  begin tx_d = 8'h00;         after_xfer_d = OUT;   end
      default: begin tx_d = 8'h00;       after_xfer_d = FIN;   end
    endcase
  end

  // Transaction FSM with all outputs registered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      phase_q     <= ISSUE;
      hold_q      <= '0;
      cnt_q       <= '0;
      addr_q      <= 24'h000000;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= 8'h00;
      spi_start_q <= 1'b0;
      spi_tx_q    <= 8'h00;
      cs_n_q      <= 1'b1;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req) begin
            addr_q  <= addr;
            cnt_q   <= (len == '0) ? {1'b1, {LEN_WIDTH{1'b0}}} : {1'b0, len};
            cs_n_q  <= 1'b0;
            busy_q  <= 1'b1;
            phase_q <= ISSUE;
            state_q <= CMD;
          end
        end
        CMD, A2, A1, A0, DUMMY, DATA: begin
          case (phase_q)
            ISSUE: begin
              spi_start_q <= 1'b1;
              spi_tx_q    <= tx_d;
              hold_q      <= '0;
              phase_q     <= WAIT_HI;
            end
            WAIT_HI: begin
              if (spi_busy) begin
                spi_start_q <= 1'b0;
                phase_q     <= WAIT_LO;
              end else if (hold_q == HOLD_LAST) begin
                // Core never acknowledged: abort, closing the transaction with an error.
                spi_start_q <= 1'b0;
                cs_n_q      <= 1'b1;
                busy_q      <= 1'b0;
                done_q      <= 1'b1;
                err_q       <= 1'b1;
                phase_q     <= ISSUE;
                state_q     <= FIN;
              end else begin
                hold_q <= hold_q + HW'(1);
              end
            end
            WAIT_LO: begin
              if (!spi_busy) begin
                if (state_q == DATA) begin
                  rd_data_q  <= spi_rx;
                  rd_valid_q <= 1'b1;
                end
                phase_q <= ISSUE;
                state_q <= after_xfer_d;
              end
            end
            default: phase_q <= ISSUE;
          endcase
        end
        OUT: begin
          if (rd_ready) begin
            rd_valid_q <= 1'b0;
            cnt_q      <= cnt_q - CNT_ONE;
            phase_q    <= ISSUE;
            if (cnt_q == CNT_ONE) begin
              cs_n_q  <= 1'b1;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= FIN;
            end else begin
              state_q <= DATA;
            end
          end
        end
        FIN:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign rd_data    = rd_data_q;
  assign rd_valid   = rd_valid_q;
  assign spi_start  = spi_start_q;
  assign spi_tx     = spi_tx_q;
  assign flash_cs_n = cs_n_q;

endmodule

// File: tb/tb_spi_flash_reader.sv
// Randomized bench for spi_flash_reader: flash/SPI-core model, per-cycle protocol monitor, scoreboard.
`timescale 1ns/1ps
module tb_spi_flash_reader;
  localparam int LW = 8;
`ifdef SPI_FLASH_FAST_READ_EN
  localparam logic [7:0] OPC = 8'h0B;
  localparam int HDR = 5;
`else
  localparam logic [7:0] OPC = 8'h03;
  localparam int HDR = 4;
`endif

  logic clk = 1'b0, reset = 1'b0, req = 1'b0, rd_ready = 1'b1;
  logic [23:0] addr = 24'h0;
  logic [LW-1:0] len = '0;
  logic busy, done, err, rd_valid, spi_start, flash_cs_n, spi_busy;
  logic [7:0] rd_data, spi_tx, spi_rx;

  spi_flash_reader #(.LEN_WIDTH(LW), .START_HOLD_MAX(63)) dut (
    .clk(clk), .reset(reset), .req(req), .addr(addr), .len(len), .busy(busy), .done(done),
    .err(err), .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready), .spi_start(spi_start),
    .spi_tx(spi_tx), .spi_rx(spi_rx), .spi_busy(spi_busy), .flash_cs_n(flash_cs_n));

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int hs_cnt = 0, start_hi_cnt = 0, done_cnt = 0, exp_n = 0;
  logic exp_err = 1'b0, mon_en = 1'b0;
  logic [7:0] exp_data[$], exp_tx[$], tx_log[$], fixed_rx[$];
  logic core_mute = 1'b0, fixed_en = 1'b0, stall_arm = 1'b0;
  int rdy_mode = 0, stall_left = 0;
  int core_cnt, core_idx, core_delay, core_want;
  logic [23:0] core_addr;
  logic prev_hold = 1'b0, prev_act = 1'b0;
  logic [7:0] prev_data = 8'h00, prev_tx = 8'h00;

  function automatic logic [7:0] mem_byte(input logic [23:0] a);
    return (a[7:0] ^ a[15:8] ^ a[23:16]) + 8'h5B;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Flash device behind a byte-level SPI core with random acknowledge and busy latency.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      spi_busy <= 1'b0; spi_rx <= 8'h00; core_cnt <= 0; core_idx <= 0;
      core_delay <= 0; core_want <= 0; core_addr <= 24'h0;
    end else if (spi_busy) begin
      if (core_cnt <= 1) spi_busy <= 1'b0;
      else core_cnt <= core_cnt - 1;
    end else if (flash_cs_n) begin
      core_idx <= 0;
    end else if (spi_start && !core_mute) begin
      if (core_delay < core_want) begin
        core_delay <= core_delay + 1;
      end else begin
        tx_log.push_back(spi_tx);
        spi_busy   <= 1'b1;
        core_cnt   <= $urandom_range(1, 4);
        core_delay <= 0;
        core_want  <= $urandom_range(0, 3);
        core_idx   <= core_idx + 1;
        if (core_idx == 1) core_addr[23:16] <= spi_tx;
        if (core_idx == 2) core_addr[15:8]  <= spi_tx;
        if (core_idx == 3) core_addr[7:0]   <= spi_tx;
        if (core_idx >= HDR) begin
          if (fixed_en) spi_rx <= (fixed_rx.size() > 0) ? fixed_rx.pop_front() : 8'h00;
          else spi_rx <= mem_byte(core_addr + 24'(core_idx - HDR));
        end
      end
    end
  end

  // Monitor, scoreboard and rd_ready driver, all on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (reset && mon_en) begin
        chk("busy_matches_cs", busy, !flash_cs_n);
        if (spi_start) begin
          start_hi_cnt++;
          chk("no_start_while_valid", rd_valid, 1'b0);
        end
        if (prev_act && (spi_start || spi_busy)) chk("tx_stable", spi_tx, prev_tx);
        if (prev_hold) begin
          chk("valid_held", rd_valid, 1'b1);
          chk("data_held", rd_data, prev_data);
        end
        if (done) begin
          done_cnt++;
          chk("err_at_done", err, exp_err);
          chk("handshakes", hs_cnt, exp_n);
          chk("cs_n_at_done", flash_cs_n, 1'b1);
          if (exp_err) chk("start_hold_cycles", start_hi_cnt, 63);
          chk("tx_count", tx_log.size(), exp_tx.size());
          for (int i = 0; i < tx_log.size() && i < exp_tx.size(); i++)
            chk($sformatf("tx_byte%0d", i), tx_log[i], exp_tx[i]);
        end
        if (err) chk("err_with_done", done, 1'b1);
        if (stall_arm && rd_valid) begin
          stall_left = 20;
          stall_arm  = 1'b0;
        end
        if (stall_left > 0) begin
          rd_ready = 1'b0;
          stall_left--;
        end else if (rdy_mode == 1) begin
          rd_ready = 1'($urandom_range(0, 1));
        end else begin
          rd_ready = 1'b1;
        end
        if (rd_valid && rd_ready) begin
          if (exp_data.size() > 0) chk("rd_data", rd_data, exp_data.pop_front());
          else chk("rd_data_unexpected", exp_data.size(), 1);
          hs_cnt++;
        end
        prev_hold = rd_valid && !rd_ready;
        prev_data = rd_data;
        prev_act  = spi_start || spi_busy;
        prev_tx   = spi_tx;
      end else begin
        prev_hold = 1'b0;
        prev_act  = 1'b0;
        rd_ready  = 1'b1;
      end
    end
  end

  task automatic expect_read(input logic [23:0] a, input int n);
    exp_tx.delete(); exp_data.delete();
    exp_tx.push_back(OPC);
    exp_tx.push_back(a[23:16]); exp_tx.push_back(a[15:8]); exp_tx.push_back(a[7:0]);
`ifdef SPI_FLASH_FAST_READ_EN
    exp_tx.push_back(8'h00);
`endif
    for (int i = 0; i < n; i++) begin
      exp_tx.push_back(8'h00);
      exp_data.push_back(mem_byte(a + 24'(i)));
    end
    exp_n = n; exp_err = 1'b0;
  endtask

  task automatic run_txn(input logic [23:0] a, input logic [LW-1:0] l, input int budget);
    int d0, k;
    @(negedge clk); #2;
    hs_cnt = 0; start_hi_cnt = 0; tx_log.delete(); d0 = done_cnt;
    req = 1'b1; addr = a; len = l;
    @(negedge clk); #2;
    req = 1'b0; addr = $urandom; len = $urandom;
    chk("busy_after_req", busy, 1'b1);
    k = 0;
    while (done_cnt == d0 && k < budget) begin
      if (k == 5) req = 1'b1;
      if (k == 6) req = 1'b0;
      @(negedge clk); #2;
      k++;
    end
    req = 1'b0;
    chk("done_within_budget", done_cnt, d0 + 1);
    repeat (4) @(negedge clk);
    #2;
    chk("single_done", done_cnt, d0 + 1);
    chk("data_all_consumed", exp_data.size(), 0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cs_n"}, flash_cs_n, 1'b1);
    chk({tag, "_spi_start"}, spi_start, 1'b0);
    chk({tag, "_spi_tx"}, spi_tx, 8'h00);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_err"}, err, 1'b0);
    chk({tag, "_rd_valid"}, rd_valid, 1'b0);
    chk({tag, "_rd_data"}, rd_data, 8'h00);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    #2 reset = 1'b1;
    mon_en = 1'b1;

    // Plain read with a pinned core response.
    expect_read(24'h012345, 2);
    exp_tx.delete();
    exp_tx.push_back(OPC); exp_tx.push_back(8'h01); exp_tx.push_back(8'h23); exp_tx.push_back(8'h45);
`ifdef SPI_FLASH_FAST_READ_EN
    exp_tx.push_back(8'h00);
`endif
    exp_tx.push_back(8'h00); exp_tx.push_back(8'h00);
    exp_data.delete(); exp_data.push_back(8'hAA); exp_data.push_back(8'h55);
    fixed_en = 1'b1; fixed_rx.delete(); fixed_rx.push_back(8'hAA); fixed_rx.push_back(8'h55);
    run_txn(24'h012345, 8'd2, 400);
    fixed_en = 1'b0;

    // Top-of-array address is sent unchanged; flash model wraps to 0.
    expect_read(24'hFFFFFF, 2);
    exp_data.delete(); exp_data.push_back(8'h5A); exp_data.push_back(8'h5B);
    run_txn(24'hFFFFFF, 8'd2, 400);

    expect_read(24'h000000, 1);
    run_txn(24'h000000, 8'd1, 400);

    // len = 0 means 256 bytes, with random backpressure.
    rdy_mode = 1;
    expect_read(24'h00F0A0, 256);
    run_txn(24'h00F0A0, 8'd0, 20000);
    rdy_mode = 0;

    // Long stall after the first byte.
    stall_arm = 1'b1;
    expect_read(24'h3C0011, 3);
    run_txn(24'h3C0011, 8'd3, 600);

    for (int t = 0; t < 10; t++) begin
      logic [23:0] ra;
      int rn;
      ra = 24'($urandom);
      rn = $urandom_range(1, 6);
      rdy_mode = $urandom_range(0, 1);
      expect_read(ra, rn);
      run_txn(ra, LW'(rn), 1000);
    end
    rdy_mode = 0;

    // SPI core never acknowledges.
    core_mute = 1'b1;
    exp_tx.delete(); exp_data.delete(); exp_n = 0; exp_err = 1'b1;
    run_txn(24'h123456, 8'd4, 400);
    core_mute = 1'b0;

    // Asynchronous reset in the middle of the A1 exchange.
    begin
      int k;
      expect_read(24'h5A6B7C, 4);
      @(negedge clk); #2;
      hs_cnt = 0; start_hi_cnt = 0; tx_log.delete();
      req = 1'b1; addr = 24'h5A6B7C; len = 8'd4;
      @(negedge clk); #2;
      req = 1'b0;
      k = 0;
      while (tx_log.size() < 3 && k < 200) begin
        @(negedge clk); #2;
        k++;
      end
      chk("reached_a1", tx_log.size(), 3);
      chk("a1_byte_live", spi_tx, 8'h6B);
      mon_en = 1'b0;
      #1 reset = 1'b0;
      #1 chk_reset_outputs("midreset");
      @(negedge clk); #2 reset = 1'b1;
      mon_en = 1'b1;
    end
    expect_read(24'hABCDEF, 3);
    run_txn(24'hABCDEF, 8'd3, 600);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    errors++;
    $display("FAIL watchdog expired t=%0t", $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
